ps2_keycode_tracker: RTL and testbench



---
 rtl/ps2_pkg.sv | 48 ++++
 rtl/ps2_byte_rx.sv | 109 ++++++++++
 rtl/ps2_keycode_tracker.sv | 133 +++++++++++++
 tb/tb_ps2_keycode_tracker.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types, PS/2 prefix bytes, HID usage codes and the Set-2 to HID translation.
package ps2_pkg;

  typedef enum logic [1:0] {DEC_IDLE, DEC_EXT, DEC_BRK, DEC_EXT_BRK} dec_state_e;
  typedef enum logic {RX_IDLE, RX_DATA} rx_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam logic [7:0] HID_NONE  = 8'h00;
  localparam logic [7:0] HID_A     = 8'h04;
  localparam logic [7:0] HID_D     = 8'h07;
  localparam logic [7:0] HID_S     = 8'h16;
  localparam logic [7:0] HID_W     = 8'h1A;
  localparam logic [7:0] HID_ENTER = 8'h28;
  localparam logic [7:0] HID_SPACE = 8'h2C;
  localparam logic [7:0] HID_RIGHT = 8'h4F;
  localparam logic [7:0] HID_LEFT  = 8'h50;
  localparam logic [7:0] HID_DOWN  = 8'h51;
  localparam logic [7:0] HID_UP    = 8'h52;

  // Unsupported keys map to HID_NONE so the table ignores them.
  function automatic logic [7:0] ps2_to_hid(input logic [7:0] code, input logic ext);
    logic [7:0] hid;
    hid = HID_NONE;
    if (ext) begin
      case (code)
        8'h74:   hid = HID_RIGHT;
        8'h6B:   hid = HID_LEFT;
        8'h72:   hid = HID_DOWN;
        8'h75:   hid = HID_UP;
        default: hid = HID_NONE;
      endcase
    end else begin
      case (code)
        8'h1D:   hid = HID_W;
        8'h1C:   hid = HID_A;
        8'h1B:   hid = HID_S;
        8'h23:   hid = HID_D;
        8'h29:   hid = HID_SPACE;
        8'h5A:   hid = HID_ENTER;
        default: hid = HID_NONE;
      endcase
    end
    return hid;
  endfunction

endpackage

// File: rtl/ps2_byte_rx.sv
// PS/2 byte receiver: synchronisers, falling-edge detect, 11-bit framing,
// odd-parity check and an inter-edge timeout that abandons partial frames.
module ps2_byte_rx
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       parity_err
);

  localparam int unsigned TimeoutW = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]          clk_sync_q;
  logic [1:0]          data_sync_q;
  rx_state_e           state_q, state_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [8:0]          shift_q, shift_d;
  logic [TimeoutW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]          byte_q, byte_d;
  logic                valid_q, valid_d;
  logic                perr_q, perr_d;

  logic fall;
  logic data_s;

  // Index 1 is the synchronised level; index 2 is its one-cycle-old copy.
  assign fall   = clk_sync_q[2] & ~clk_sync_q[1];
  assign data_s = data_sync_q[1];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    to_cnt_d  = to_cnt_q;
    byte_d    = byte_q;
    valid_d   = 1'b0;
    perr_d    = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        to_cnt_d = '0;
        if (fall && !data_s) begin
          state_d   = RX_DATA;
          bit_cnt_d = 4'd1;
        end
      end
      RX_DATA: begin
        if (fall) begin
          to_cnt_d = '0;
          if (bit_cnt_q == 4'd10) begin
            state_d   = RX_IDLE;
            bit_cnt_d = 4'd0;
            // shift_q holds 8 data bits plus parity; odd total is required.
            if (data_s && (^shift_q)) begin
              valid_d = 1'b1;
              byte_d  = shift_q[7:0];
            end else begin
              perr_d = 1'b1;
            end
          end else begin
            shift_d   = {data_s, shift_q[8:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (to_cnt_q == TimeoutW'(TIMEOUT_CYCLES)) begin
          state_d   = RX_IDLE;
          bit_cnt_d = 4'd0;
          to_cnt_d  = '0;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      clk_sync_q  <= 3'b111;
      data_sync_q <= 2'b11;
      state_q     <= RX_IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= '0;
      to_cnt_q    <= '0;
      byte_q      <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      to_cnt_q    <= to_cnt_d;
      byte_q      <= byte_d;
      valid_q     <= valid_d;
      perr_q      <= perr_d;
    end
  end

  assign rx_byte    = byte_q;
  assign byte_valid = valid_q;
  assign parity_err = perr_q;

endmodule

// File: rtl/ps2_keycode_tracker.sv
// PS/2 keyboard to held-key table: prefix decoder plus KEY_SLOTS-entry HID slot table.
// Define KEYCODE_COMPACT_EN to keep held keys packed from slot 0 on every break.
module ps2_keycode_tracker
  import ps2_pkg::*;
#(
  parameter int unsigned KEY_SLOTS      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   ps2_clk,
  input  logic                   ps2_data,
  output logic [8*KEY_SLOTS-1:0] keycode,
  output logic                   key_event,
  output logic                   parity_err
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_perr;

  ps2_byte_rx #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .Clk        (Clk),
    .Reset      (Reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_byte    (rx_byte),
    .byte_valid (rx_valid),
    .parity_err (rx_perr)
  );

  dec_state_e dec_q, dec_d;
  logic       is_make, is_brk, is_ext;
  logic [7:0] hid;

  always_comb begin
    dec_d   = dec_q;
    is_make = 1'b0;
    is_brk  = 1'b0;
    is_ext  = 1'b0;
    if (rx_perr) begin
      dec_d = DEC_IDLE;
    end else if (rx_valid) begin
      unique case (dec_q)
        DEC_IDLE: begin
          if (rx_byte == PS2_EXT)      dec_d = DEC_EXT;
          else if (rx_byte == PS2_BRK) dec_d = DEC_BRK;
          else                         is_make = 1'b1;
        end
        DEC_EXT: begin
          if (rx_byte == PS2_BRK) begin
            dec_d = DEC_EXT_BRK;
          end else if (rx_byte != PS2_EXT) begin
            is_make = 1'b1;
            is_ext  = 1'b1;
            dec_d   = DEC_IDLE;
          end
        end
        DEC_BRK: begin
          is_brk = 1'b1;
          dec_d  = DEC_IDLE;
        end
        DEC_EXT_BRK: begin
          is_brk = 1'b1;
          is_ext = 1'b1;
          dec_d  = DEC_IDLE;
        end
        default: dec_d = DEC_IDLE;
      endcase
    end
  end

  assign hid = ps2_to_hid(rx_byte, is_ext);

  logic [KEY_SLOTS-1:0][7:0] slots_q, slots_d;
  logic                      key_event_q, key_event_d;
  logic                      present, placed, found;

  always_comb begin
    slots_d = slots_q;
    present = 1'b0;
    placed  = 1'b0;
    found   = 1'b0;
    for (int i = 0; i < int'(KEY_SLOTS); i++) begin
      if (slots_q[i] == hid) present = 1'b1;
    end
    if (is_make && (hid != HID_NONE) && !present) begin
      for (int i = 0; i < int'(KEY_SLOTS); i++) begin
        if (!placed && (slots_q[i] == HID_NONE)) begin
          slots_d[i] = hid;
          placed     = 1'b1;
        end
      end
    end
    if (is_brk && (hid != HID_NONE)) begin
`ifdef KEYCODE_COMPACT_EN
      // Makes never duplicate a code, so at most one slot matches.
      for (int i = 0; i < int'(KEY_SLOTS) - 1; i++) begin
        if (slots_q[i] == hid) found = 1'b1;
        if (found) slots_d[i] = slots_q[i+1];
      end
      if (found || (slots_q[KEY_SLOTS-1] == hid)) slots_d[KEY_SLOTS-1] = HID_NONE;
`else
      for (int i = 0; i < int'(KEY_SLOTS); i++) begin
        if (slots_q[i] == hid) begin
          slots_d[i] = HID_NONE;
          found      = 1'b1;
        end
      end
`endif
    end
    key_event_d = (slots_d != slots_q);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      dec_q       <= DEC_IDLE;
      slots_q     <= '0;
      key_event_q <= 1'b0;
    end else begin
      dec_q       <= dec_d;
      slots_q     <= slots_d;
      key_event_q <= key_event_d;
    end
  end

  assign keycode    = slots_q;
  assign key_event  = key_event_q;
  assign parity_err = rx_perr;

endmodule

// File: tb/tb_ps2_keycode_tracker.sv
// Scoreboard bench for ps2_keycode_tracker: expected keycodes are queued as
// frames are sent, and a monitor pops them on each key_event pulse.
module tb_ps2_keycode_tracker;

  localparam int unsigned TO = 4000;  // shortened timeout keeps the run brief
  localparam int unsigned H  = 10;    // Clk cycles per PS/2 clock half-period

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ps2_clk;
  logic        ps2_data;
  logic [31:0] keycode;
  logic        key_event;
  logic        parity_err;

  ps2_keycode_tracker #(
    .KEY_SLOTS      (4),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .keycode    (keycode),
    .key_event  (key_event),
    .parity_err (parity_err)
  );

  always #10 Clk = ~Clk;

  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  int unsigned last_fall = 0;
  logic [31:0] exp_kc_q[$];
  int          perr_pending = 0;
  logic [31:0] prev_kc = '0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every output pulse.
  always @(negedge Clk) begin
    int unsigned lat;
    if (!Reset) begin
      if (key_event) begin
        total++;
        if (exp_kc_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected key_event: keycode %h expected no event", keycode);
        end else begin
          check("keycode at key_event", keycode, exp_kc_q.pop_front());
          lat = cyc - last_fall;
          total++;
          if (lat < 3 || lat > 6) begin
            bad++;
            $display("FAIL event latency: got %0d cycles expected 3..6", lat);
          end
        end
      end else begin
        check("keycode stable without event", keycode, prev_kc);
      end
      if (parity_err) begin
        total++;
        if (perr_pending == 0) begin
          bad++;
          $display("FAIL unexpected parity_err: got 1 expected 0");
        end else begin
          perr_pending--;
        end
      end
    end
    prev_kc <= keycode;
  end

  task automatic ps2_bit(input logic v);
    @(negedge Clk);
    ps2_data = v;
    repeat (H) @(negedge Clk);
    ps2_clk   = 1'b0;
    last_fall = cyc;
    repeat (H) @(negedge Clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    logic [10:0] f;
    f = {1'b1, (~(^b)) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(f[i]);
    repeat (20) @(negedge Clk);
  endtask

  task automatic send_partial(input int n);
    logic [10:0] f;
    f = 11'b101_1011_0110;
    for (int i = 0; i < n; i++) ps2_bit(f[i]);
  endtask

  task automatic drain(input string name);
    repeat (20) @(negedge Clk);
    check({name, " events drained"}, exp_kc_q.size(), 0);
    check({name, " parity_err drained"}, perr_pending, 0);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(negedge Clk);
    check("reset keycode", keycode, 32'h0);
    check("reset key_event", {31'b0, key_event}, 32'h0);
    check("reset parity_err", {31'b0, parity_err}, 32'h0);
    Reset = 1'b0;
    repeat (5) @(negedge Clk);
  endtask

  initial begin
    Reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    do_reset();

    // Single make.
    exp_kc_q.push_back(32'h0000_001A);
    send_frame(8'h1D, 0);
    drain("make W");
    check("make W final", keycode, 32'h0000_001A);
    do_reset();

    // Extended make and break.
    exp_kc_q.push_back(32'h0000_0052);
    send_frame(8'hE0, 0);
    send_frame(8'h75, 0);
    exp_kc_q.push_back(32'h0000_0000);
    send_frame(8'hE0, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h75, 0);
    drain("ext up");
    check("ext up final", keycode, 32'h0);
    do_reset();

    // Fill all slots, then overflow.
    exp_kc_q.push_back(32'h0000_001A);
    send_frame(8'h1D, 0);
    exp_kc_q.push_back(32'h0000_041A);
    send_frame(8'h1C, 0);
    exp_kc_q.push_back(32'h0016_041A);
    send_frame(8'h1B, 0);
    exp_kc_q.push_back(32'h0716_041A);
    send_frame(8'h23, 0);
    send_frame(8'hE0, 0);
    send_frame(8'h75, 0);
    drain("full table");
    check("full table final", keycode, 32'h0716_041A);
    do_reset();

    // Typematic repeat.
    exp_kc_q.push_back(32'h0000_001A);
    for (int i = 0; i < 3; i++) send_frame(8'h1D, 0);
    drain("repeat");
    check("repeat final", keycode, 32'h0000_001A);
    do_reset();

    // Bad parity.
    perr_pending++;
    send_frame(8'h1C, 1);
    drain("bad parity");
    check("bad parity final", keycode, 32'h0);
    do_reset();

    // Parity error cancels a pending break prefix.
    send_frame(8'hF0, 0);
    perr_pending++;
    send_frame(8'h55, 1);
    exp_kc_q.push_back(32'h0000_0004);
    send_frame(8'h1C, 0);
    drain("perr after F0");
    check("perr after F0 final", keycode, 32'h0000_0004);
    do_reset();

    // Timeout abandons a partial frame.
    send_partial(5);
    repeat (TO + 100) @(negedge Clk);
    exp_kc_q.push_back(32'h0000_0007);
    send_frame(8'h23, 0);
    drain("timeout");
    check("timeout final", keycode, 32'h0000_0007);
    do_reset();

    // Reset mid-frame.
    exp_kc_q.push_back(32'h0000_001A);
    send_frame(8'h1D, 0);
    exp_kc_q.push_back(32'h0000_041A);
    send_frame(8'h1C, 0);
    send_partial(5);
    do_reset();
    exp_kc_q.push_back(32'h0000_0016);
    send_frame(8'h1B, 0);
    drain("reset mid-frame");
    check("reset mid-frame final", keycode, 32'h0000_0016);
    do_reset();

    // Break leaves a hole, or compacts when enabled.
    exp_kc_q.push_back(32'h0000_001A);
    send_frame(8'h1D, 0);
    exp_kc_q.push_back(32'h0000_041A);
    send_frame(8'h1C, 0);
`ifdef KEYCODE_COMPACT_EN
    exp_kc_q.push_back(32'h0000_0004);
`else
    exp_kc_q.push_back(32'h0000_0400);
`endif
    send_frame(8'hF0, 0);
    send_frame(8'h1D, 0);
    drain("break W");
`ifdef KEYCODE_COMPACT_EN
    check("break W final", keycode, 32'h0000_0004);
`else
    check("break W final", keycode, 32'h0000_0400);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
